// File: rtl/aes256_cbc_stream_framer_if.sv
// AXI-Stream style interface shared by the framer's payload input and its
// framed output toward the AES-256 CBC core.
//   tdata  : WIDTH-bit beat payload
//   tkeep  : byte enables (all ones on every framed beat)
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a message / frame
//   tuser  : encrypt flag (1 = encrypt, 0 = decrypt)
interface axis_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tkeep;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/aes256_cbc_stream_framer.sv
// Transmit-side framer for the AES-256 CBC cores. Accepts a key/IV/direction
// command, then emits key low half, key high half and IV, followed by the
// payload re-blocked into 128-bit blocks (zero padded when the message ends
// mid-block). tuser carries the encrypt flag on every beat; tlast marks the
// final beat of the final block.
//
// Ports:
//   Clk, Rst_n   : clock, asynchronous active-low reset
//   Cmd_*        : key/IV/direction command (valid/ready handshake)
//   S_axis       : raw payload in, S_AXIS_WIDTH bits per beat
//   M_axis       : framed stream out, M_AXIS_WIDTH bits per beat
//   Busy         : high whenever a frame is in progress
//   Pad_err      : one-cycle pulse when payload tlast arrived mid-block
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a command, Cmd_ready high
// ST_KEY_0 | sending key[127:0], LSB chunk first
// ST_KEY_1 | sending key[255:128], LSB chunk first
// ST_IV    | sending iv[127:0], LSB chunk first
// ST_FILL  | collecting one 128-bit payload block
// ST_SEND  | sending the collected block
module aes256_cbc_stream_framer #(
    parameter int S_AXIS_WIDTH = 8,
    parameter int M_AXIS_WIDTH = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Cmd_valid,
    output logic         Cmd_ready,
    input  logic [255:0] Cmd_key,
    input  logic [127:0] Cmd_iv,
    input  logic         Cmd_encrypt,
    axis_if.slave        S_axis,
    axis_if.master       M_axis,
    output logic         Busy,
    output logic         Pad_err
);
    localparam int IN_BEATS  = 128 / S_AXIS_WIDTH;
    localparam int OUT_BEATS = 128 / M_AXIS_WIDTH;
    localparam int IN_CW     = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
    localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_0,
        ST_KEY_1,
        ST_IV,
        ST_FILL,
        ST_SEND
    } state_t;

    state_t              state;
    logic [IN_CW-1:0]    in_cnt;
    logic [OUT_CW-1:0]   out_cnt;
    logic [255:0]        key_reg;
    logic [127:0]        iv_reg;
    logic [127:0]        blk_reg;
    logic                encrypt_reg;
    logic                last_reg;
    logic                pad_reg;
    // Holds Cmd_ready low while reset is asserted even though state is ST_IDLE.
    logic                ready_en;

    logic                in_last;
    logic                out_last;
    logic                m_valid;
    logic                m_hs;
    logic                s_hs;
    logic [M_AXIS_WIDTH-1:0] m_data;
    logic                unused_sideband;

    assign in_last  = (in_cnt == IN_LAST);
    assign out_last = (out_cnt == OUT_LAST);
    assign m_valid  = (state == ST_KEY_0) || (state == ST_KEY_1) ||
                      (state == ST_IV)    || (state == ST_SEND);
    assign m_hs     = m_valid && M_axis.tready;
    assign s_hs     = (state == ST_FILL) && S_axis.tvalid;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            key_reg     <= '0;
            iv_reg      <= '0;
            blk_reg     <= '0;
            encrypt_reg <= 1'b0;
            last_reg    <= 1'b0;
            pad_reg     <= 1'b0;
            ready_en    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            pad_reg  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Cmd_valid && Cmd_ready) begin
                        key_reg     <= Cmd_key;
                        iv_reg      <= Cmd_iv;
                        encrypt_reg <= Cmd_encrypt;
                        last_reg    <= 1'b0;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        state       <= ST_KEY_0;
                    end
                end
                ST_KEY_0: begin
                    if (m_hs) begin
                        out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                        if (out_last) state <= ST_KEY_1;
                    end
                end
                ST_KEY_1: begin
                    if (m_hs) begin
                        out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                        if (out_last) state <= ST_IV;
                    end
                end
                ST_IV: begin
                    if (m_hs) begin
                        out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                        if (out_last) state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (s_hs) begin
                        // The first chunk of a block also clears the rest of
                        // the buffer, so an early tlast leaves zero padding.
                        if (in_cnt == '0)
                            blk_reg <= 128'(S_axis.tdata);
                        else
                            blk_reg[int'(in_cnt)*S_AXIS_WIDTH +: S_AXIS_WIDTH] <= S_axis.tdata;
                        if (in_last || S_axis.tlast) begin
                            in_cnt   <= '0;
                            last_reg <= S_axis.tlast;
                            pad_reg  <= S_axis.tlast && !in_last;
                            state    <= ST_SEND;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (m_hs) begin
                        out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                        if (out_last) state <= last_reg ? ST_IDLE : ST_FILL;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        m_data = '0;
        case (state)
            ST_KEY_0: m_data = key_reg[int'(out_cnt)*M_AXIS_WIDTH +: M_AXIS_WIDTH];
            ST_KEY_1: m_data = key_reg[128 + int'(out_cnt)*M_AXIS_WIDTH +: M_AXIS_WIDTH];
            ST_IV:    m_data = iv_reg[int'(out_cnt)*M_AXIS_WIDTH +: M_AXIS_WIDTH];
            ST_SEND:  m_data = blk_reg[int'(out_cnt)*M_AXIS_WIDTH +: M_AXIS_WIDTH];
            default:  m_data = '0;
        endcase
    end

    assign M_axis.tvalid = m_valid;
    assign M_axis.tdata  = m_data;
    assign M_axis.tkeep  = {(M_AXIS_WIDTH/8){m_valid}};
    assign M_axis.tuser  = encrypt_reg;
    assign M_axis.tlast  = (state == ST_SEND) && last_reg && out_last;
    assign S_axis.tready = (state == ST_FILL);
    assign Cmd_ready     = ready_en && (state == ST_IDLE);
    assign Busy          = (state != ST_IDLE);
    assign Pad_err       = pad_reg;

    // Payload byte enables and tuser carry nothing the cipher frame needs.
    assign unused_sideband = ^{S_axis.tkeep, S_axis.tuser};
endmodule

// File: tb/tb_aes256_cbc_stream_framer.sv
// Three framer instances: 0 = 8/8, 1 = 128/128, 2 = 8/32 with backpressure.
// Expected frames are built as byte lists: key bytes 0..31, IV bytes 0..15,
// payload bytes zero-padded to a 16-byte multiple, cut into output beats.
module tb_aes256_cbc_stream_framer;
    localparam int LIMIT = 3000;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic [255:0] cmd_key = '0;
    logic [127:0] cmd_iv = '0;
    logic         cmd_enc = 1'b0;
    logic [2:0]   cmd_valid = '0;
    logic [2:0]   s_tvalid = '0;
    logic [2:0]   s_tlast = '0;
    logic [2:0]   bp_en = '0;
    logic [2:0]   m_tready = '1;
    logic [127:0] s_tdata = '0;

    logic [2:0]   cmd_ready_w, s_tready_w, busy_w, pad_w, m_tvalid_w, m_tlast_w, m_tuser_w;
    logic [127:0] m_tdata_w [3];
    logic [15:0]  m_tkeep_w [3];

    int vectors = 0;
    int miscompares = 0;
    int stall_err = 0;
    int pad_cycles [3] = '{0, 0, 0};

    logic [7:0] out_q [3][$];
    bit         tl_q  [3][$];
    bit         us_q  [3][$];
    logic [7:0] exp_q [$];
    logic [7:0] pay_q [$];
    bit         exp_tl [$];
    bit         exp_us [$];
    int         ob, obt;

    logic         stall_p [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] data_p  [3];
    logic         last_p  [3];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int SWG = (g == 1) ? 128 : 8;
        localparam int MWG = (g == 0) ? 8 : ((g == 1) ? 128 : 32);
        axis_if #(.WIDTH(SWG)) s_if ();
        axis_if #(.WIDTH(MWG)) m_if ();
        assign s_if.tdata  = s_tdata[SWG-1:0];
        assign s_if.tkeep  = '1;
        assign s_if.tvalid = s_tvalid[g];
        assign s_if.tlast  = s_tlast[g];
        assign s_if.tuser  = 1'b0;
        assign m_if.tready = m_tready[g];
        aes256_cbc_stream_framer #(.S_AXIS_WIDTH(SWG), .M_AXIS_WIDTH(MWG)) u_dut (
            .Clk(Clk), .Rst_n(Rst_n),
            .Cmd_valid(cmd_valid[g]), .Cmd_ready(cmd_ready_w[g]),
            .Cmd_key(cmd_key), .Cmd_iv(cmd_iv), .Cmd_encrypt(cmd_enc),
            .S_axis(s_if), .M_axis(m_if),
            .Busy(busy_w[g]), .Pad_err(pad_w[g])
        );
        assign s_tready_w[g] = s_if.tready;
        assign m_tvalid_w[g] = m_if.tvalid;
        assign m_tlast_w[g]  = m_if.tlast;
        assign m_tuser_w[g]  = m_if.tuser;
        assign m_tdata_w[g]  = 128'(m_if.tdata);
        assign m_tkeep_w[g]  = 16'(m_if.tkeep);
    end

    function automatic int mbytes(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 16 : 4);
    endfunction

    function automatic int sbytes(input int g);
        return (g == 1) ? 16 : 1;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge Clk) begin
        #1;
        for (int g = 0; g < 3; g++)
            m_tready[g] = bp_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Collect output beats (handshake seen at negedge completes at next posedge)
    // and watch that a stalled beat holds its data and tlast.
    always @(negedge Clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!Rst_n) begin
                stall_p[g] = 1'b0;
            end else begin
                if (stall_p[g] && (!m_tvalid_w[g] || m_tdata_w[g] !== data_p[g] ||
                                   m_tlast_w[g] !== last_p[g]))
                    stall_err++;
                if (m_tvalid_w[g] && m_tready[g]) begin
                    for (int b = 0; b < mbytes(g); b++) out_q[g].push_back(m_tdata_w[g][8*b +: 8]);
                    tl_q[g].push_back(m_tlast_w[g]);
                    us_q[g].push_back(m_tuser_w[g]);
                end
                stall_p[g] = m_tvalid_w[g] && !m_tready[g];
                data_p[g]  = m_tdata_w[g];
                last_p[g]  = m_tlast_w[g];
                if (pad_w[g]) pad_cycles[g]++;
            end
        end
    end

    task automatic begin_frame(input int g);
        exp_q.delete(); exp_tl.delete(); exp_us.delete();
        ob  = out_q[g].size();
        obt = tl_q[g].size();
    endtask

    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic add_frame_exp(input int g, input logic [255:0] k, input logic [127:0] iv,
                                 input bit enc, input int n);
        int start = exp_q.size();
        int nb;
        for (int i = 0; i < 32; i++) exp_q.push_back(k[8*i +: 8]);
        for (int i = 0; i < 16; i++) exp_q.push_back(iv[8*i +: 8]);
        for (int i = 0; i < n; i++) exp_q.push_back(pay_q[i]);
        while ((exp_q.size() - start) % 16 != 0) exp_q.push_back(8'h00);
        nb = (exp_q.size() - start) / mbytes(g);
        for (int j = 0; j < nb; j++) begin
            exp_tl.push_back(j == nb - 1);
            exp_us.push_back(enc);
        end
    endtask

    task automatic issue_cmd(input int g, input logic [255:0] k, input logic [127:0] iv, input bit enc);
        int t = 0;
        cmd_key = k; cmd_iv = iv; cmd_enc = enc;
        cmd_valid[g] = 1'b1;
        forever begin
            @(negedge Clk);
            if (cmd_ready_w[g]) break;
            if (++t > LIMIT) begin
                vectors++; miscompares++;
                $display("FAIL cmd_timeout[%0d]: Cmd_ready still 0, expected 1", g);
                break;
            end
        end
        @(posedge Clk); #1;
        cmd_valid[g] = 1'b0;
    endtask

    task automatic send_payload(input int g, input int n);
        int sb = sbytes(g);
        int beats = n / sb;
        for (int i = 0; i < beats; i++) begin
            int t = 0;
            s_tdata = '0;
            for (int b = 0; b < sb; b++) s_tdata[8*b +: 8] = pay_q[i*sb + b];
            s_tlast[g]  = (i == beats - 1);
            s_tvalid[g] = 1'b1;
            forever begin
                @(negedge Clk);
                if (s_tready_w[g]) break;
                if (++t > LIMIT) begin
                    vectors++; miscompares++;
                    $display("FAIL s_ready_timeout[%0d]: tready 0 at beat %0d, expected 1", g, i);
                    break;
                end
            end
            @(posedge Clk); #1;
        end
        s_tvalid[g] = 1'b0;
        s_tlast[g]  = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int target);
        int t = 0;
        while (!(out_q[g].size() >= target && !busy_w[g])) begin
            @(negedge Clk);
            if (++t > LIMIT) begin
                vectors++; miscompares++;
                $display("FAIL idle_timeout[%0d]: got %0d bytes, expected %0d", g, out_q[g].size(), target);
                break;
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if ({m_tvalid_w[g], m_tlast_w[g], s_tready_w[g], cmd_ready_w[g], busy_w[g], pad_w[g]} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl[%0d]: got %b, expected 000000", g,
                         {m_tvalid_w[g], m_tlast_w[g], s_tready_w[g], cmd_ready_w[g], busy_w[g], pad_w[g]});
            end
            vectors++;
            if (m_tdata_w[g] !== '0 || m_tkeep_w[g] !== '0) begin
                miscompares++;
                $display("FAIL reset_data[%0d]: tdata %h tkeep %h, expected 0", g, m_tdata_w[g], m_tkeep_w[g]);
            end
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if ({cmd_ready_w[g], busy_w[g]} !== 2'b10) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: ready/busy %b, expected 10", g, {cmd_ready_w[g], busy_w[g]});
            end
        end
    endtask

    // Shared by all scenarios that compare a finished stream against the model.
    task automatic compare_stream(input int g, input string name);
        vectors++;
        if (out_q[g].size() - ob !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_len: got %0d bytes, expected %0d", name, out_q[g].size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < out_q[g].size(); i++) begin
            vectors++;
            if (out_q[g][ob + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s_byte[%0d]: got %h, expected %h", name, i, out_q[g][ob + i], exp_q[i]);
            end
        end
        for (int j = 0; j < exp_tl.size() && obt + j < tl_q[g].size(); j++) begin
            vectors++;
            if ({tl_q[g][obt + j], us_q[g][obt + j]} !== {exp_tl[j], exp_us[j]}) begin
                miscompares++;
                $display("FAIL %s_last_user[%0d]: got %b%b, expected %b%b", name, j,
                         tl_q[g][obt + j], us_q[g][obt + j], exp_tl[j], exp_us[j]);
            end
        end
    endtask

    task automatic test_basic_8x8();
        logic [255:0] k;
        logic [127:0] iv;
        int pc = pad_cycles[0];
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        for (int i = 0; i < 16; i++) iv[8*i +: 8] = 8'(i);
        begin_frame(0);
        fill_payload(16);
        add_frame_exp(0, k, iv, 1'b1, 16);
        issue_cmd(0, k, iv, 1'b1);
        send_payload(0, 16);
        wait_idle(0, ob + exp_q.size());
        compare_stream(0, "basic");
        vectors++;
        if (tl_q[0].size() - obt !== 64) begin
            miscompares++;
            $display("FAIL basic_beats: got %0d, expected 64", tl_q[0].size() - obt);
        end
        vectors++;
        if ({cmd_ready_w[0], busy_w[0], pad_cycles[0] - pc} !== {2'b10, 32'd0}) begin
            miscompares++;
            $display("FAIL basic_end: ready/busy %b%b pad %0d, expected 10 pad 0",
                     cmd_ready_w[0], busy_w[0], pad_cycles[0] - pc);
        end
    endtask

    task automatic test_wide_decrypt();
        logic [255:0] k = rnd256();
        logic [127:0] iv = rnd256()[127:0];
        begin_frame(1);
        fill_payload(48);
        add_frame_exp(1, k, iv, 1'b0, 48);
        issue_cmd(1, k, iv, 1'b0);
        send_payload(1, 48);
        wait_idle(1, ob + exp_q.size());
        compare_stream(1, "wide");
        vectors++;
        if (tl_q[1].size() - obt !== 6) begin
            miscompares++;
            $display("FAIL wide_beats: got %0d, expected 6", tl_q[1].size() - obt);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k = rnd256();
        logic [127:0] iv = rnd256()[127:0];
        int se = stall_err;
        bp_en[2] = 1'b1;
        begin_frame(2);
        fill_payload(32);
        add_frame_exp(2, k, iv, 1'b1, 32);
        issue_cmd(2, k, iv, 1'b1);
        send_payload(2, 32);
        wait_idle(2, ob + exp_q.size());
        bp_en[2] = 1'b0;
        compare_stream(2, "bp");
        vectors++;
        if (stall_err - se !== 0) begin
            miscompares++;
            $display("FAIL bp_stall_hold: got %0d unstable stalls, expected 0", stall_err - se);
        end
    endtask

    task automatic test_pad();
        logic [255:0] k = rnd256();
        logic [127:0] iv = rnd256()[127:0];
        int pc = pad_cycles[0];
        begin_frame(0);
        fill_payload(26);
        add_frame_exp(0, k, iv, 1'b1, 26);
        issue_cmd(0, k, iv, 1'b1);
        send_payload(0, 26);
        wait_idle(0, ob + exp_q.size());
        compare_stream(0, "pad");
        vectors++;
        if (pad_cycles[0] - pc !== 1) begin
            miscompares++;
            $display("FAIL pad_pulse: got %0d cycles, expected 1", pad_cycles[0] - pc);
        end
    endtask

    task automatic test_reset_mid_iv();
        logic [255:0] k = rnd256();
        logic [127:0] iv = rnd256()[127:0];
        int t = 0;
        begin_frame(0);
        issue_cmd(0, k, iv, 1'b0);
        while (out_q[0].size() < ob + 36) begin
            @(negedge Clk);
            if (++t > LIMIT) begin
                vectors++; miscompares++;
                $display("FAIL rst_iv_timeout: got %0d bytes, expected 36", out_q[0].size() - ob);
                break;
            end
        end
        @(posedge Clk); #1;
        vectors++;
        if (m_tvalid_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_iv_pre: tvalid %b, expected 1", m_tvalid_w[0]);
        end
        Rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_tvalid_w[0], busy_w[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_iv_async: tvalid/busy %b, expected 00", {m_tvalid_w[0], busy_w[0]});
        end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        vectors++;
        if ({cmd_ready_w[0], busy_w[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_iv_release: ready/busy %b, expected 10", {cmd_ready_w[0], busy_w[0]});
        end
        k = rnd256();
        iv = rnd256()[127:0];
        begin_frame(0);
        fill_payload(32);
        add_frame_exp(0, k, iv, 1'b1, 32);
        issue_cmd(0, k, iv, 1'b1);
        send_payload(0, 32);
        wait_idle(0, ob + exp_q.size());
        compare_stream(0, "rst_fresh");
    endtask

    task automatic test_cmd_hold();
        logic [255:0] ka = rnd256();
        logic [255:0] kb = rnd256();
        logic [127:0] iva = rnd256()[127:0];
        logic [127:0] ivb = rnd256()[127:0];
        int t = 0;
        int busy_seen = 0;
        begin_frame(0);
        fill_payload(16);
        add_frame_exp(0, ka, iva, 1'b1, 16);
        issue_cmd(0, ka, iva, 1'b1);
        send_payload(0, 16);
        cmd_key = kb; cmd_iv = ivb; cmd_enc = 1'b0;
        cmd_valid[0] = 1'b1;
        forever begin
            @(negedge Clk);
            if (busy_w[0]) begin
                busy_seen++;
                vectors++;
                if (cmd_ready_w[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_ready_busy: got %b, expected 0", cmd_ready_w[0]);
                end
            end else begin
                vectors++;
                if (cmd_ready_w[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_ready_idle: got %b, expected 1", cmd_ready_w[0]);
                end
                break;
            end
            if (++t > LIMIT) begin
                vectors++; miscompares++;
                $display("FAIL hold_timeout: busy %b, expected 0", busy_w[0]);
                break;
            end
        end
        @(posedge Clk); #1;
        cmd_valid[0] = 1'b0;
        vectors++;
        if (busy_w[0] !== 1'b1 || busy_seen < 8) begin
            miscompares++;
            $display("FAIL hold_accept: busy %b after %0d held cycles, expected 1 after >=8", busy_w[0], busy_seen);
        end
        fill_payload(16);
        add_frame_exp(0, kb, ivb, 1'b0, 16);
        send_payload(0, 16);
        wait_idle(0, ob + exp_q.size());
        compare_stream(0, "hold");
    endtask

    initial begin
        test_reset();
        test_basic_8x8();
        test_wide_decrypt();
        test_backpressure();
        test_pad();
        test_reset_mid_iv();
        test_cmd_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
